// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and state encoding for the Mini-CPU main controller.
// Opcodes, funct codes and ALU operation codes live here.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_ALU   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// R-type funct to ALU operation decoder.
// Flags any funct outside the supported set as illegal.
module alu_op_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    unique case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Multi-cycle main control FSM for the Mini-CPU datapath.
// Sequences fetch/decode/execute/memory/writeback and drives the strobes.
module alu_operand_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW  = 6,
  parameter int FNW  = 6,
  parameter int AOPW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [OPW-1:0]  opcode,
  input  logic [FNW-1:0]  funct,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            alu_src_b,
  output logic [AOPW-1:0] alu_op,
  output logic            ir_write,
  output logic            pc_inc,
  output logic            pc_branch,
  output logic            pc_jump,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            trap,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [AOPW-1:0] alu_op_q, alu_op_d;
  logic            src_b_q, src_b_d;
  logic            rtype_q, rtype_d;

  logic [3:0] dec_op;
  logic       dec_illegal;

  alu_op_decoder u_dec (
    .funct   (funct),
    .alu_op  (dec_op),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    rtype_d = rtype_q;
    unique case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        rtype_d = (opcode == OP_R);
        case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_EXEC_R:   state_d = dec_illegal ? S_TRAP : S_WB_ALU;
      S_EXEC_I:   state_d = S_WB_ALU;
      S_MEM_ADDR: begin
        state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: begin
        if (mem_ready) state_d = run ? S_FETCH : S_IDLE;
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: begin
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand select and ALU op are registered against the state being
  // entered, so writeback and memory phases simply keep the last value.
  always_comb begin
    alu_op_d = alu_op_q;
    src_b_d  = src_b_q;
    unique case (state_d)
      S_EXEC_R: begin
        alu_op_d = dec_op;
        src_b_d  = 1'b0;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_op_d = ALU_ADD;
        src_b_d  = 1'b1;
      end
      S_BRANCH: begin
        alu_op_d = ALU_SUB;
        src_b_d  = 1'b0;
      end
      S_WB_ALU, S_MEM_RD, S_WB_MEM, S_MEM_WR: ;
      default: begin
        alu_op_d = '0;
        src_b_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      alu_op_q <= '0;
      src_b_q  <= 1'b0;
      rtype_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_op_q <= alu_op_d;
      src_b_q  <= src_b_d;
      rtype_q  <= rtype_d;
    end
  end

  assign alu_src_b  = src_b_q;
  assign alu_op     = alu_op_q;
  assign ir_write   = (state_q == S_FETCH) & mem_ready;
  assign pc_inc     = (state_q == S_FETCH) & mem_ready;
  assign pc_branch  = (state_q == S_BRANCH) & zero;
  assign pc_jump    = (state_q == S_JUMP);
  assign mem_read   = (state_q == S_FETCH) | (state_q == S_MEM_RD);
  assign mem_write  = (state_q == S_MEM_WR);
  assign reg_write  = (state_q == S_WB_ALU) | (state_q == S_WB_MEM);
  assign reg_dst    = (state_q == S_WB_ALU) & rtype_q;
  assign mem_to_reg = (state_q == S_WB_MEM);
  assign trap       = (state_q == S_TRAP);
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized bench for alu_operand_sequencer against a per-instruction
// phase-list reference model.
module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset, run, zero, mem_ready;
  logic [5:0] opcode, funct;
  logic       alu_src_b;
  logic [3:0] alu_op;
  logic       ir_write, pc_inc, pc_branch, pc_jump;
  logic       mem_read, mem_write, reg_write, reg_dst;
  logic       mem_to_reg, trap, busy;

  alu_operand_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .ir_write   (ir_write),
    .pc_inc     (pc_inc),
    .pc_branch  (pc_branch),
    .pc_jump    (pc_jump),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .trap       (trap),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [15:0] obs;
  assign obs = {busy, trap, alu_src_b, alu_op, ir_write, pc_inc,
                pc_branch, pc_jump, mem_read, mem_write, reg_write,
                reg_dst, mem_to_reg};

  localparam logic [15:0] BUSY  = 16'h8000;
  localparam logic [15:0] TRAPB = 16'h4000;
  localparam logic [15:0] SRCB  = 16'h2000;
  localparam logic [15:0] IRW   = 16'h0100;
  localparam logic [15:0] PCI   = 16'h0080;
  localparam logic [15:0] PCB   = 16'h0040;
  localparam logic [15:0] PCJ   = 16'h0020;
  localparam logic [15:0] MRD   = 16'h0010;
  localparam logic [15:0] MWR   = 16'h0008;
  localparam logic [15:0] RGW   = 16'h0004;
  localparam logic [15:0] RDST  = 16'h0002;
  localparam logic [15:0] M2R   = 16'h0001;
  localparam logic [15:0] NOALU = 16'hC1FF;

  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;

  localparam int K_PLAIN = 0;
  localparam int K_FETCH = 1;
  localparam int K_WAIT  = 2;
  localparam int K_BR    = 3;
  localparam int K_TRAP  = 4;

  typedef struct {
    string       name;
    logic [15:0] exp;
    bit          alu_chk;
    int          kind;
  } ph_t;

  ph_t ph[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom % 2);
  endfunction

  function automatic logic [15:0] aop(input logic [3:0] o);
    return {3'b000, o, 9'b0};
  endfunction

  function automatic ph_t mk(input string n, input logic [15:0] e,
                             input bit c, input int k);
    ph_t p;
    p.name = n;
    p.exp = e;
    p.alu_chk = c;
    p.kind = k;
    return p;
  endfunction

  // {illegal, alu_op} for an R-type funct
  function automatic logic [4:0] ref_alu(input logic [5:0] f);
    case (f)
      6'h20:   return {1'b0, 4'b0010};
      6'h22:   return {1'b0, 4'b0110};
      6'h24:   return {1'b0, 4'b0000};
      6'h25:   return {1'b0, 4'b0001};
      6'h2A:   return {1'b0, 4'b0111};
      default: return {1'b1, 4'b0000};
    endcase
  endfunction

  task automatic build(input logic [5:0] opc, input logic [5:0] fn);
    logic [4:0] a;
    ph.delete();
    ph.push_back(mk("fetch", BUSY | MRD, 0, K_FETCH));
    ph.push_back(mk("decode", BUSY, 0, K_PLAIN));
    case (opc)
      6'h00: begin
        a = ref_alu(fn);
        ph.push_back(mk("exec_r", BUSY | aop(a[3:0]), !a[4], K_PLAIN));
        if (a[4]) ph.push_back(mk("trap", BUSY | TRAPB, 0, K_TRAP));
        else ph.push_back(mk("wb_r", BUSY | RGW | RDST | aop(a[3:0]),
                             1, K_PLAIN));
      end
      6'h08: begin
        ph.push_back(mk("exec_i", BUSY | SRCB | aop(A_ADD), 1, K_PLAIN));
        ph.push_back(mk("wb_i", BUSY | RGW | SRCB | aop(A_ADD), 1, K_PLAIN));
      end
      6'h23: begin
        ph.push_back(mk("mem_addr", BUSY | SRCB | aop(A_ADD), 1, K_PLAIN));
        ph.push_back(mk("mem_rd", BUSY | MRD | SRCB | aop(A_ADD), 1, K_WAIT));
        ph.push_back(mk("wb_mem", BUSY | RGW | M2R, 0, K_PLAIN));
      end
      6'h2B: begin
        ph.push_back(mk("mem_addr", BUSY | SRCB | aop(A_ADD), 1, K_PLAIN));
        ph.push_back(mk("mem_wr", BUSY | MWR | SRCB | aop(A_ADD), 1, K_WAIT));
      end
      6'h04: ph.push_back(mk("branch", BUSY | aop(A_SUB), 1, K_BR));
      6'h02: ph.push_back(mk("jump", BUSY | PCJ, 0, K_PLAIN));
      default: ph.push_back(mk("trap", BUSY | TRAPB, 0, K_TRAP));
    endcase
  endtask

  task automatic cycle(input logic rs, input logic rn, input logic mr,
                       input logic z);
    @(posedge clk);
    #1;
    reset = rs;
    run = rn;
    mem_ready = mr;
    zero = z;
    @(negedge clk);
  endtask

  task automatic idle_cyc(input string tag);
    cycle(1'b0, 1'b1, rb(), rb());
    check(tag, obs, 16'h0000);
  endtask

  task automatic do_instr(input logic [5:0] opc, input logic [5:0] fn,
                          input int drop_at, input bit rst_wr,
                          input int min_lows);
    logic [15:0] e, m;
    logic        mr, z, rn, rs;
    int          n, lows;
    bit          done;
    opcode = opc;
    funct = fn;
    build(opc, fn);
    n = 0;
    rn = 1'b1;
    for (int i = 0; i < ph.size(); i++) begin
      if (ph[i].kind == K_TRAP) begin
        for (int k = 0; k < 3; k++) begin
          cycle(1'b0, rb(), rb(), rb());
          check("trap", obs & NOALU, BUSY | TRAPB);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        check("trap_rst", obs & NOALU, BUSY | TRAPB);
        idle_cyc("trap_clr");
        return;
      end
      lows = 0;
      do begin
        mr = ($urandom % 4) != 0;
        if (ph[i].kind == K_WAIT && lows < min_lows) mr = 1'b0;
        else if (lows >= 3) mr = 1'b1;
        z = rb();
        rn = (n >= drop_at) ? 1'b0 : 1'b1;
        rs = rst_wr && (ph[i].name == "mem_wr");
        cycle(rs, rn, mr, z);
        e = ph[i].exp;
        if (ph[i].kind == K_FETCH && mr) e = e | IRW | PCI;
        if (ph[i].kind == K_BR && z) e = e | PCB;
        m = ph[i].alu_chk ? 16'hFFFF : NOALU;
        check(ph[i].name, obs & m, e & m);
        n++;
        if (rs) begin
          idle_cyc("rst_abort");
          return;
        end
        done = !(ph[i].kind == K_FETCH || ph[i].kind == K_WAIT) || mr;
        if (!mr) lows++;
      end while (!done);
    end
    if (!rn) idle_cyc("run_drop");
  endtask

  logic [5:0] ops [8];
  logic [5:0] fns [6];

  initial begin
    ops = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h07};
    reset = 1'b1;
    run = 1'b0;
    mem_ready = 1'b0;
    zero = 1'b0;
    opcode = 6'h00;
    funct = 6'h00;
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("reset", obs, 16'h0000);
    idle_cyc("idle_run");

    do_instr(6'h00, 6'h22, 100, 0, 0);
    do_instr(6'h23, 6'h00, 100, 0, 3);
    do_instr(6'h04, 6'h00, 100, 0, 0);
    do_instr(6'h04, 6'h00, 100, 0, 0);
    do_instr(6'h3F, 6'h20, 100, 0, 0);
    do_instr(6'h00, 6'h07, 100, 0, 0);
    do_instr(6'h2B, 6'h00, 100, 1, 0);
    do_instr(6'h08, 6'h00, 2, 0, 0);
    do_instr(6'h02, 6'h00, 100, 0, 0);

    for (int t = 0; t < 120; t++) begin
      int drop;
      drop = ($urandom % 4 == 0) ? int'($urandom % 8) : 100;
      do_instr(ops[$urandom % 8], fns[$urandom % 6], drop,
               ($urandom % 5) == 0, int'($urandom % 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
